// File: rtl/control_decode_pipe.sv
// Registered RV32I(+M) ID-stage control decoder with a valid/ready output register,
// flush, illegal detection and an optional multi-cycle issue hold for MUL/DIV ops.
module control_decode_pipe #(
  parameter int unsigned M_EXT         = 1,
  parameter int unsigned MULDIV_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        memw_o,
  output logic        branch_o,
  output logic        memrd_o,
  output logic        regwrite_o,
  output logic        memtoreg_o,
  output logic        opBsel_o,
  output logic [2:0]  aluop_o,
  output logic [1:0]  opAsel_o,
  output logic [1:0]  extendsel_o,
  output logic [1:0]  nextPCsel_o,
  output logic        muldiv_o,
  output logic        illegal_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o
);

  localparam int unsigned CW      = $clog2(MULDIV_CYCLES) + 1;
  localparam bit          MD_HOLD = (MULDIV_CYCLES > 32'd1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_MDWAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic       memw;
    logic       branch;
    logic       memrd;
    logic       regwrite;
    logic       memtoreg;
    logic       opbsel;
    logic [2:0] aluop;
    logic [1:0] opasel;
    logic [1:0] extendsel;
    logic [1:0] nextpcsel;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    if (instr[1:0] != 2'b11) begin
      c.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        7'b0110011: begin
          if (instr[31:25] == 7'b0000001 && M_EXT == 32'd0) begin
            c.illegal = 1'b1;
          end else begin
            c.regwrite = 1'b1;
            c.aluop    = 3'b000;
            c.muldiv   = (instr[31:25] == 7'b0000001);
          end
        end
        7'b0000011: begin
          c.memrd    = 1'b1;
          c.regwrite = 1'b1;
          c.memtoreg = 1'b1;
          c.opbsel   = 1'b1;
          c.aluop    = 3'b100;
        end
        7'b0100011: begin
          c.memw      = 1'b1;
          c.opbsel    = 1'b1;
          c.aluop     = 3'b101;
          c.extendsel = 2'b10;
        end
        7'b1100011: begin
          c.branch    = 1'b1;
          c.aluop     = 3'b010;
          c.nextpcsel = 2'b01;
        end
        7'b0010011: begin
          c.regwrite = 1'b1;
          c.opbsel   = 1'b1;
          c.aluop    = 3'b001;
        end
        7'b1100111: begin
          c.regwrite  = 1'b1;
          c.aluop     = 3'b011;
          c.opasel    = 2'b10;
          c.nextpcsel = 2'b11;
        end
        7'b1101111: begin
          c.regwrite  = 1'b1;
          c.aluop     = 3'b011;
          c.opasel    = 2'b10;
          c.nextpcsel = 2'b10;
        end
        7'b0110111: begin
          c.regwrite  = 1'b1;
          c.opbsel    = 1'b1;
          c.aluop     = 3'b110;
          c.opasel    = 2'b11;
          c.extendsel = 2'b01;
        end
        7'b0010111: begin
          c.regwrite  = 1'b1;
          c.opbsel    = 1'b1;
          c.aluop     = 3'b110;
          c.opasel    = 2'b01;
          c.extendsel = 2'b01;
        end
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  ctrl_t         ctrl_q, dec_s;
  logic [4:0]    rd_q, rs1_q, rs2_q;
  logic [2:0]    funct3_q;
  logic          accept_s, load_s;

  assign dec_s    = decode(instr_i);
  assign ready_o  = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & ready_i);
  assign accept_s = valid_i & ready_o;

  // Next state: flush wins; a held MUL/DIV counts down before the word turns valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    load_s  = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY, ST_FULL: begin
          if (accept_s) begin
            load_s = 1'b1;
            if (dec_s.muldiv && MD_HOLD) begin
              state_d = ST_MDWAIT;
              valid_d = 1'b0;
              cnt_d   = CW'(MULDIV_CYCLES - 32'd1);
            end else begin
              state_d = ST_FULL;
              valid_d = 1'b1;
              cnt_d   = '0;
            end
          end else if (state_q == ST_EMPTY || ready_i) begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_FULL;
            valid_d = 1'b1;
          end
        end
        ST_MDWAIT: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_d == '0) begin
            state_d = ST_FULL;
            valid_d = 1'b1;
          end else begin
            state_d = ST_MDWAIT;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and the ID/EX output register; fields move only on a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      rd_q     <= 5'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
      funct3_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      if (load_s) begin
        ctrl_q   <= dec_s;
        rd_q     <= instr_i[11:7];
        rs1_q    <= instr_i[19:15];
        rs2_q    <= instr_i[24:20];
        funct3_q <= instr_i[14:12];
      end
    end
  end

  assign valid_o     = valid_q;
  assign memw_o      = ctrl_q.memw;
  assign branch_o    = ctrl_q.branch;
  assign memrd_o     = ctrl_q.memrd;
  assign regwrite_o  = ctrl_q.regwrite;
  assign memtoreg_o  = ctrl_q.memtoreg;
  assign opBsel_o    = ctrl_q.opbsel;
  assign aluop_o     = ctrl_q.aluop;
  assign opAsel_o    = ctrl_q.opasel;
  assign extendsel_o = ctrl_q.extendsel;
  assign nextPCsel_o = ctrl_q.nextpcsel;
  assign muldiv_o    = ctrl_q.muldiv;
  assign illegal_o   = ctrl_q.illegal;
  assign rd_o        = rd_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
  assign funct3_o    = funct3_q;

endmodule

// File: tb/tb_control_decode_pipe.sv
// Bench for control_decode_pipe: two instances (M_EXT=1/8 cycles, M_EXT=0/1 cycle) driven
// in lockstep, compared against a transaction-level reference built from the decode table.
module tb_control_decode_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] instr_i;
  logic        valid_i, flush_i, ready_i;

  logic        ready_w [2];
  logic        valid_w [2];
  logic [34:0] obs_w   [2];

  logic memw_a, branch_a, memrd_a, regwrite_a, memtoreg_a, opb_a, md_a, ill_a;
  logic [2:0] aluop_a, f3_a;
  logic [1:0] opa_a, ext_a, npc_a;
  logic [4:0] rd_a, rs1_a, rs2_a;
  logic memw_b, branch_b, memrd_b, regwrite_b, memtoreg_b, opb_b, md_b, ill_b;
  logic [2:0] aluop_b, f3_b;
  logic [1:0] opa_b, ext_b, npc_b;
  logic [4:0] rd_b, rs1_b, rs2_b;

  always #5 clk_i = ~clk_i;

  control_decode_pipe #(.M_EXT(1), .MULDIV_CYCLES(8)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .valid_i(valid_i),
    .ready_o(ready_w[0]), .flush_i(flush_i), .valid_o(valid_w[0]), .ready_i(ready_i),
    .memw_o(memw_a), .branch_o(branch_a), .memrd_o(memrd_a), .regwrite_o(regwrite_a),
    .memtoreg_o(memtoreg_a), .opBsel_o(opb_a), .aluop_o(aluop_a), .opAsel_o(opa_a),
    .extendsel_o(ext_a), .nextPCsel_o(npc_a), .muldiv_o(md_a), .illegal_o(ill_a),
    .rd_o(rd_a), .rs1_o(rs1_a), .rs2_o(rs2_a), .funct3_o(f3_a)
  );

  control_decode_pipe #(.M_EXT(0), .MULDIV_CYCLES(1)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .valid_i(valid_i),
    .ready_o(ready_w[1]), .flush_i(flush_i), .valid_o(valid_w[1]), .ready_i(ready_i),
    .memw_o(memw_b), .branch_o(branch_b), .memrd_o(memrd_b), .regwrite_o(regwrite_b),
    .memtoreg_o(memtoreg_b), .opBsel_o(opb_b), .aluop_o(aluop_b), .opAsel_o(opa_b),
    .extendsel_o(ext_b), .nextPCsel_o(npc_b), .muldiv_o(md_b), .illegal_o(ill_b),
    .rd_o(rd_b), .rs1_o(rs1_b), .rs2_o(rs2_b), .funct3_o(f3_b)
  );

  assign obs_w[0] = {memw_a, branch_a, memrd_a, regwrite_a, memtoreg_a, opb_a, aluop_a,
                     opa_a, ext_a, npc_a, md_a, ill_a, rd_a, rs1_a, rs2_a, f3_a};
  assign obs_w[1] = {memw_b, branch_b, memrd_b, regwrite_b, memtoreg_b, opb_b, aluop_b,
                     opa_b, ext_b, npc_b, md_b, ill_b, rd_b, rs1_b, rs2_b, f3_b};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int unsigned mext [2] = '{1, 0};
  int          mcyc [2] = '{8, 1};

  // Reference: an op is "held" from acceptance until EX takes it; it is visible from m_at on.
  bit          m_have [2];
  int          m_at   [2];
  logic [34:0] m_word [2];

  logic [6:0] ops [9] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                          7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};

  // Word layout: memw,branch,memrd,regwr,memtoreg,opB | aluop opA ext nPC | muldiv illegal | rd rs1 rs2 f3
  function automatic logic [34:0] ref_word(input logic [31:0] ins, input int unsigned me);
    logic [14:0] ctl;
    logic        md, ill;
    ctl = 15'd0;
    md  = 1'b0;
    ill = 1'b0;
    case (ins[6:0])
      7'b0110011: ctl = {6'b000100, 3'b000, 2'b00, 2'b00, 2'b00};
      7'b0000011: ctl = {6'b001111, 3'b100, 2'b00, 2'b00, 2'b00};
      7'b0100011: ctl = {6'b100001, 3'b101, 2'b00, 2'b10, 2'b00};
      7'b1100011: ctl = {6'b010000, 3'b010, 2'b00, 2'b00, 2'b01};
      7'b0010011: ctl = {6'b000101, 3'b001, 2'b00, 2'b00, 2'b00};
      7'b1100111: ctl = {6'b000100, 3'b011, 2'b10, 2'b00, 2'b11};
      7'b1101111: ctl = {6'b000100, 3'b011, 2'b10, 2'b00, 2'b10};
      7'b0110111: ctl = {6'b000101, 3'b110, 2'b11, 2'b01, 2'b00};
      7'b0010111: ctl = {6'b000101, 3'b110, 2'b01, 2'b01, 2'b00};
      default:    ill = 1'b1;
    endcase
    if (ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001) begin
      if (me != 0) md = 1'b1;
      else begin
        ill = 1'b1;
        ctl = 15'd0;
      end
    end
    return {ctl, md, ill, ins[11:7], ins[19:15], ins[24:20], ins[14:12]};
  endfunction

  task automatic chk(input string tag, input logic [34:0] o, input logic [34:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  // One cycle: drive, compare, advance the reference, clock.
  task automatic step(input logic [31:0] ins, input logic v, input logic rdy, input logic fl);
    bit ev, er;
    instr_i = ins;
    valid_i = v;
    ready_i = rdy;
    flush_i = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      ev = m_have[k] && (cyc >= m_at[k]);
      er = !m_have[k] || (ev && rdy);
      chk(k == 0 ? "valid_a" : "valid_b", {34'd0, valid_w[k]}, {34'd0, ev});
      chk(k == 0 ? "ready_a" : "ready_b", {34'd0, ready_w[k]}, {34'd0, er});
      if (ev) chk(k == 0 ? "word_a" : "word_b", obs_w[k], m_word[k]);
      if (fl) m_have[k] = 1'b0;
      else if (v && er) begin
        m_have[k] = 1'b1;
        m_word[k] = ref_word(ins, mext[k]);
        m_at[k]   = cyc + (m_word[k][19] ? mcyc[k] : 1);
      end else if (ev && rdy) m_have[k] = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic reset_check();
    rst_ni = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_have[k] = 1'b0;
      chk(k == 0 ? "rst_word_a" : "rst_word_b", obs_w[k], 35'd0);
      chk(k == 0 ? "rst_valid_a" : "rst_valid_b", {34'd0, valid_w[k]}, 35'd0);
      chk(k == 0 ? "rst_ready_a" : "rst_ready_b", {34'd0, ready_w[k]}, 35'd1);
    end
    #2;
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) r[6:0] = ops[sel];
    else if (sel == 9) begin
      r[6:0]   = 7'b0110011;
      r[31:25] = 7'b0000001;
    end
    return r;
  endfunction

  initial begin
    rst_ni  = 1'b0;
    instr_i = 32'd0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    m_have  = '{1'b0, 1'b0};
    m_at    = '{0, 0};
    m_word  = '{35'd0, 35'd0};
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset in the middle of a MUL/DIV hold
    step(32'h02208033, 1'b1, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    reset_check();
    step(32'h0, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream
    step(32'h00500093, 1'b1, 1'b1, 1'b0);
    step(32'h0000a103, 1'b1, 1'b1, 1'b0);
    step(32'h0020a023, 1'b1, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);

    // Backpressure on lui
    step(32'h000012b7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h00500093, 1'b1, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);

    // MUL hold, then drain
    step(32'h02208033, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(32'h00500093, 1'b1, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);

    // Flush during MDWAIT and during FULL with EX stalled, jal presented alongside
    step(32'h02208033, 1'b1, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    step(32'h0080006f, 1'b1, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    step(32'h00500093, 1'b1, 1'b0, 1'b0);
    step(32'h0080006f, 1'b1, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1, 1'b0);
    step(32'h0080006f, 1'b1, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b1, 1'b0);

    // Illegal and AUIPC
    step(32'hffffffff, 1'b1, 1'b1, 1'b0);
    step(32'h00001197, 1'b1, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 24) == 0));
    step(32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(32'h0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
